apb_to_obi_intf: RTL and testbench
==================================

# apb_to_obi_intf

APB-subordinate to OBI-manager bridge. Accepts single APB transfers from an upstream APB requester and replays each one as exactly one OBI request/response pair toward an OBI subordinate (memory or peripheral crossbar). The bridge is the return-direction counterpart of the OBI-to-APB bridge: it lets APB-only initiators, such as debug or test access ports, reach OBI-native targets. It has one outstanding transaction at a time, registered OBI outputs, and a registered APB response.

## Interface
- No parameters. Address and data widths come from the connected interfaces: 32-bit address, 32-bit data, 4-bit strobe.
- `clk_i`  in  1  clock, all logic on rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `apb_i`  APB.Slave  intf  upstream APB port. Inputs: psel, penable, paddr, pwrite, pwdata, pstrb, pprot. Outputs: pready, prdata, pslverr.
- `obi_o`  OBI_BUS.Manager  intf  downstream OBI port. Outputs: req, addr, we, wdata, be, rready, plus tie-offs. Inputs: gnt, rvalid, rdata, err.

## Operation
- FSM states: IDLE, REQ, RESP, DONE. Reset state is IDLE.
- **IDLE**
  - req=0, pready=0.
  - If psel=1, capture paddr, pwrite, pwdata and pstrb into the request registers and go to REQ.
  - penable is ignored for launch, so a transfer launches from the setup cycle.
- **REQ**
  - req=1; addr/we/wdata/be are driven from the request registers and held stable until gnt.
  - If gnt=1, go to RESP. Otherwise stay, with no retraction of req.
- **RESP**
  - req=0.
  - If rvalid=1, capture rdata into prdata_q and err into pslverr_q, then go to DONE.
  - For writes, rdata is captured unchanged; APB ignores it.
- **DONE**
  - pready=1 for exactly one cycle; prdata=prdata_q, pslverr=pslverr_q.
  - Then go to IDLE.
- Outside DONE, pready=0 and pslverr=0. prdata holds its last captured value.
- rready is tied to 1. pprot is ignored.
- Tie-offs: reqpar=0, rreadypar=0, aid=0, a_optional=0.
- If psel is deasserted mid-transfer (an APB protocol violation), the OBI transaction still completes and DONE still pulses pready. No state is left dangling.
- gnt and rvalid in the same cycle while in REQ: rvalid is ignored. OBI forbids a response in the grant cycle.
- Reset mid-operation returns the FSM to IDLE immediately, regardless of any outstanding OBI transaction. Recovery of the target is system-level.

## Timing
- Reset values:
  - state = IDLE.
  - req, pready and pslverr = 0.
  - prdata, addr, wdata, be and we = 0.
- Best case, with gnt in the first REQ cycle and rvalid one cycle later:
  - cycle 0: setup phase (psel=1, penable=0).
  - cycles 1–3: access phase, with pready high in cycle 3.
  - Total 4 cycles per APB transfer, i.e. 2 APB wait states.
- Each extra gnt-wait cycle or rvalid-wait cycle adds one cycle.
- Back-to-back: a new setup in the cycle after DONE launches from IDLE with no bubble beyond the APB setup cycle.
- No combinational path from any OBI input to any APB output, or from any APB input to any OBI output. Every output is driven from a register or from the state.

## Structure
- Single module, no sub-modules.
- state_e is a local enum, not shared.
- No package additions are needed; widths come from the interfaces.
- Request registers (addr, we, wdata, be) are loaded only in IDLE with psel=1.
- Response registers (prdata_q, pslverr_q) are loaded only in RESP with rvalid=1.

## Test plan
- **Write, zero-latency target:** paddr=0x1000_0010, pwdata=0xDEAD_BEEF, pstrb=4'hF; gnt=1 immediately, rvalid next cycle, err=0 → req high for 1 cycle with matching addr/wdata/be/we=1; pready in cycle 3; pslverr=0.
- **Read with stalls:** gnt delayed 3 cycles, rvalid delayed 2 cycles after gnt, rdata=0x1234_5678 → req held stable for 4 cycles; pready in cycle 8 with prdata=0x1234_5678.
- **Error response:** read returns err=1, rdata=0xFFFF_FFFF → pslverr=1 and prdata=0xFFFF_FFFF during the pready cycle only; pslverr=0 on the next transfer, which has err=0.
- **Byte strobe:** write with pstrb=4'b0100 → be=4'b0100, we=1, wdata unchanged.
- **Back-to-back:** write 0x0000_0001 then read at the same address returning 0x0000_0001 → each transfer produces exactly one req/gnt and one rvalid, with pready once per transfer.
- **Reset mid-operation:** rst_ni asserted while in RESP → req=0, pready=0, state IDLE; after release, a fresh read completes normally.

Source files
------------

// File: rtl/apb_to_obi_intf_pkg.sv
// Shared widths and the request bundle for the APB-to-OBI bridge and its bus interfaces.
// Widths follow the connected buses: 32-bit address/data, 4-bit byte strobe.
package apb_to_obi_intf_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned PROT_W = 3;
    localparam int unsigned AID_W  = 1;
    localparam int unsigned AOPT_W = 1;

    // One captured APB transfer, replayed verbatim as an OBI address phase.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] be;
    } obi_req_t;

endpackage

// File: rtl/APB.sv
// APB bus bundle: requester drives the select/address/data group, completer drives the response.
interface APB;

    logic                                     psel;
    logic                                     penable;
    logic [apb_to_obi_intf_pkg::ADDR_W-1:0]   paddr;
    logic                                     pwrite;
    logic [apb_to_obi_intf_pkg::DATA_W-1:0]   pwdata;
    logic [apb_to_obi_intf_pkg::STRB_W-1:0]   pstrb;
    logic [apb_to_obi_intf_pkg::PROT_W-1:0]   pprot;
    logic                                     pready;
    logic [apb_to_obi_intf_pkg::DATA_W-1:0]   prdata;
    logic                                     pslverr;

    modport Slave (
        input  psel, penable, paddr, pwrite, pwdata, pstrb, pprot,
        output pready, prdata, pslverr
    );

    modport Master (
        output psel, penable, paddr, pwrite, pwdata, pstrb, pprot,
        input  pready, prdata, pslverr
    );

endinterface

// File: rtl/OBI_BUS.sv
// OBI bus bundle. Handshake: an address phase transfers on a cycle with req=1 and gnt=1;
// a response transfers on a cycle with rvalid=1 and rready=1, never in its own grant cycle.
interface OBI_BUS;

    logic                                     req;
    logic                                     gnt;
    logic [apb_to_obi_intf_pkg::ADDR_W-1:0]   addr;
    logic                                     we;
    logic [apb_to_obi_intf_pkg::STRB_W-1:0]   be;
    logic [apb_to_obi_intf_pkg::DATA_W-1:0]   wdata;
    logic [apb_to_obi_intf_pkg::AID_W-1:0]    aid;
    logic [apb_to_obi_intf_pkg::AOPT_W-1:0]   a_optional;
    logic                                     reqpar;
    logic                                     rvalid;
    logic                                     rready;
    logic                                     rreadypar;
    logic [apb_to_obi_intf_pkg::DATA_W-1:0]   rdata;
    logic                                     err;

    modport Manager (
        output req, addr, we, be, wdata, aid, a_optional, reqpar, rready, rreadypar,
        input  gnt, rvalid, rdata, err
    );

    modport Subordinate (
        input  req, addr, we, be, wdata, aid, a_optional, reqpar, rready, rreadypar,
        output gnt, rvalid, rdata, err
    );

endinterface

// File: rtl/apb_to_obi_intf.sv
// APB completer that replays each APB transfer as one OBI request/response pair.
// One transaction in flight; OBI address phase and APB response are both driven from registers.
module apb_to_obi_intf
    import apb_to_obi_intf_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    APB.Slave          apb_i,
    OBI_BUS.Manager    obi_o,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e            state_q;
    state_e            state_d;
    obi_req_t          req_q;
    logic [DATA_W-1:0] prdata_q;
    logic              pslverr_q;

    logic              launch;
    logic              capture;

    // penable and pprot carry no information the bridge needs: launch happens on the setup cycle.
    logic              unused_apb;
    assign unused_apb = ^{apb_i.penable, apb_i.pprot};

    assign launch  = (state_q == IDLE) && apb_i.psel;
    assign capture = (state_q == RESP) && obi_o.rvalid;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A dropped psel does not abort: once launched, the OBI transaction always runs to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (apb_i.psel) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (obi_o.gnt) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (obi_o.rvalid) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q <= '0;
        end else if (launch) begin
            req_q.addr  <= apb_i.paddr;
            req_q.we    <= apb_i.pwrite;
            req_q.wdata <= apb_i.pwdata;
            req_q.be    <= apb_i.pstrb;
        end
    end

    // rdata is kept on writes too; APB simply ignores prdata for a write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else if (capture) begin
            prdata_q  <= obi_o.rdata;
            pslverr_q <= obi_o.err;
        end
    end

    always_comb begin
        obi_o.req     = 1'b0;
        apb_i.pready  = 1'b0;
        apb_i.pslverr = 1'b0;
        case (state_q)
            REQ: begin
                obi_o.req = 1'b1;
            end
            DONE: begin
                apb_i.pready  = 1'b1;
                apb_i.pslverr = pslverr_q;
            end
            default: begin
            end
        endcase
    end

    assign obi_o.addr       = req_q.addr;
    assign obi_o.we         = req_q.we;
    assign obi_o.wdata      = req_q.wdata;
    assign obi_o.be         = req_q.be;
    assign obi_o.rready     = 1'b1;
    assign obi_o.reqpar     = 1'b0;
    assign obi_o.rreadypar  = 1'b0;
    assign obi_o.aid        = '0;
    assign obi_o.a_optional = '0;

    assign apb_i.prdata = prdata_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_apb_to_obi_intf.sv
// Bench for apb_to_obi_intf: plays the APB requester and an OBI memory target, and checks
// request fields, latency, response data and error routing against a byte-addressed memory model.
module tb_apb_to_obi_intf;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [1:0] dbg_state;

    APB     apb_bus ();
    OBI_BUS obi_bus ();

    apb_to_obi_intf dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .apb_i     (apb_bus),
        .obi_o     (obi_bus),
        .dbg_state (dbg_state)
    );

    always #5 clk_i = ~clk_i;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_q [$];
    logic [31:0] last_prdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    function automatic void mem_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] cur;
        cur = mem_read(a);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
        end
        mem[a] = cur;
    endfunction

    // One APB transfer against the target model. Entered and left on a falling edge; the last
    // falling edge is inside the pready cycle, so a following call forms a back-to-back transfer.
    // gd: extra cycles before gnt; rd: extra cycles after gnt before rvalid.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] wd,
                        input logic [3:0] st, input int gd, input int rd, input logic e,
                        input logic [31:0] alt_rdata, input logic drop);
        logic [31:0] resp;
        int          gnt_cyc;
        int          rv_cyc;
        int          rdy_cyc;
        resp    = (w || e) ? alt_rdata : mem_read(a);
        gnt_cyc = gd + 1;
        rv_cyc  = gd + rd + 2;
        rdy_cyc = gd + rd + 3;
        exp_q.push_back(resp);

        @(negedge clk_i);
        chk("idle_req", {31'b0, obi_bus.req}, 32'd0);
        chk("idle_pready", {31'b0, apb_bus.pready}, 32'd0);
        chk("prdata_hold", apb_bus.prdata, last_prdata);
        apb_bus.psel    = 1'b1;
        apb_bus.penable = 1'b0;
        apb_bus.paddr   = a;
        apb_bus.pwrite  = w;
        apb_bus.pwdata  = wd;
        apb_bus.pstrb   = st;
        apb_bus.pprot   = 3'($urandom_range(0, 7));
        @(posedge clk_i);
        #1;
        apb_bus.penable = 1'b1;
        if (drop) apb_bus.psel = 1'b0;

        for (int cyc = 1; cyc <= rdy_cyc; cyc++) begin
            @(negedge clk_i);
            obi_bus.gnt    = 1'b0;
            obi_bus.rvalid = 1'b0;
            obi_bus.rdata  = $urandom;
            obi_bus.err    = 1'($urandom_range(0, 1));
            chk("req", {31'b0, obi_bus.req}, {31'b0, cyc <= gnt_cyc});
            if (cyc <= gnt_cyc) begin
                chk("addr", obi_bus.addr, a);
                chk("we", {31'b0, obi_bus.we}, {31'b0, w});
                chk("be", {28'b0, obi_bus.be}, {28'b0, st});
                chk("wdata", obi_bus.wdata, wd);
            end
            if (cyc == gnt_cyc) begin
                obi_bus.gnt    = 1'b1;
                // A response in the grant cycle is illegal and must be ignored.
                obi_bus.rvalid = 1'($urandom_range(0, 1));
            end
            if (cyc == rv_cyc) begin
                obi_bus.rvalid = 1'b1;
                obi_bus.rdata  = resp;
                obi_bus.err    = e;
            end
            chk("pready", {31'b0, apb_bus.pready}, {31'b0, cyc == rdy_cyc});
            chk("pslverr", {31'b0, apb_bus.pslverr}, {31'b0, (cyc == rdy_cyc) && e});
            if (cyc == rdy_cyc) begin
                last_prdata = exp_q.pop_front();
                chk("prdata", apb_bus.prdata, last_prdata);
                apb_bus.psel    = 1'b0;
                apb_bus.penable = 1'b0;
            end
        end
        if (w && !e) mem_write(a, wd, st);
    endtask

    initial begin
        logic [31:0] addr_tab [4];
        addr_tab[0] = 32'h1000_0010;
        addr_tab[1] = 32'h2000_0000;
        addr_tab[2] = 32'h0000_0004;
        addr_tab[3] = 32'h0000_0030;
        last_prdata = 32'h0;

        rst_ni          = 1'b0;
        apb_bus.psel    = 1'b0;
        apb_bus.penable = 1'b0;
        apb_bus.paddr   = 32'h0;
        apb_bus.pwrite  = 1'b0;
        apb_bus.pwdata  = 32'h0;
        apb_bus.pstrb   = 4'h0;
        apb_bus.pprot   = 3'h0;
        obi_bus.gnt     = 1'b0;
        obi_bus.rvalid  = 1'b0;
        obi_bus.rdata   = 32'h0;
        obi_bus.err     = 1'b0;
        repeat (3) @(negedge clk_i);

        chk("rst_req", {31'b0, obi_bus.req}, 32'd0);
        chk("rst_pready", {31'b0, apb_bus.pready}, 32'd0);
        chk("rst_pslverr", {31'b0, apb_bus.pslverr}, 32'd0);
        chk("rst_prdata", apb_bus.prdata, 32'h0);
        chk("rst_addr", obi_bus.addr, 32'h0);
        chk("rst_wdata", obi_bus.wdata, 32'h0);
        chk("rst_be", {28'b0, obi_bus.be}, 32'h0);
        chk("rst_we", {31'b0, obi_bus.we}, 32'h0);
        chk("rst_state_idle", {30'b0, dbg_state}, 32'h0);
        chk("rready_tied", {31'b0, obi_bus.rready}, 32'h1);
        chk("tieoffs", {28'b0, obi_bus.reqpar, obi_bus.rreadypar, obi_bus.aid, obi_bus.a_optional}, 32'h0);
        rst_ni = 1'b1;

        // zero-latency write
        xfer(32'h1000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, 0, 1'b0, $urandom, 1'b0);
        // seed a location, then read it back with gnt and rvalid stalls
        xfer(32'h2000_0000, 1'b1, 32'h1234_5678, 4'hF, 1, 0, 1'b0, $urandom, 1'b0);
        xfer(32'h2000_0000, 1'b0, 32'h0, 4'h0, 3, 2, 1'b0, 32'h0, 1'b0);
        // error read, then a clean read must not carry pslverr
        xfer(32'h0000_0100, 1'b0, 32'h0, 4'h0, 0, 1, 1'b1, 32'hFFFF_FFFF, 1'b0);
        xfer(32'h1000_0010, 1'b0, 32'h0, 4'h0, 0, 0, 1'b0, 32'h0, 1'b0);
        // single byte lane write, read back merged word
        xfer(32'h0000_0004, 1'b1, 32'hA5A5_5A5A, 4'b0100, 0, 0, 1'b0, $urandom, 1'b0);
        xfer(32'h0000_0004, 1'b0, 32'h0, 4'h0, 2, 0, 1'b0, 32'h0, 1'b0);
        // back-to-back write/read, same address
        xfer(32'h0000_0030, 1'b1, 32'h0000_0001, 4'hF, 0, 0, 1'b0, $urandom, 1'b0);
        xfer(32'h0000_0030, 1'b0, 32'h0, 4'h0, 0, 0, 1'b0, 32'h0, 1'b0);
        // psel dropped after launch: the transfer must still complete
        xfer(32'h2000_0000, 1'b0, 32'h0, 4'h0, 1, 1, 1'b0, 32'h0, 1'b1);

        // reset while waiting for rvalid
        @(negedge clk_i);
        apb_bus.psel   = 1'b1;
        apb_bus.paddr  = 32'h1000_0010;
        apb_bus.pwrite = 1'b0;
        @(posedge clk_i);
        #1;
        apb_bus.penable = 1'b1;
        @(negedge clk_i);
        chk("mid_req_high", {31'b0, obi_bus.req}, 32'd1);
        obi_bus.gnt = 1'b1;
        @(negedge clk_i);
        obi_bus.gnt = 1'b0;
        chk("mid_req_low", {31'b0, obi_bus.req}, 32'd0);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_req", {31'b0, obi_bus.req}, 32'd0);
        chk("mid_rst_pready", {31'b0, apb_bus.pready}, 32'd0);
        chk("mid_rst_state", {30'b0, dbg_state}, 32'd0);
        apb_bus.psel    = 1'b0;
        apb_bus.penable = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        chk("post_rst_addr", obi_bus.addr, 32'h0);
        last_prdata = 32'h0;
        xfer(32'h1000_0010, 1'b0, 32'h0, 4'h0, 0, 0, 1'b0, 32'h0, 1'b0);

        // randomized traffic over a small address set so reads hit earlier writes
        for (int n = 0; n < 30; n++) begin
            logic [31:0] a;
            logic        w;
            logic        e;
            a = addr_tab[$urandom_range(0, 3)];
            w = 1'($urandom_range(0, 1));
            e = ($urandom_range(0, 9) == 0);
            xfer(a, w, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                 $urandom_range(0, 3), e, $urandom, ($urandom_range(0, 7) == 0));
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
        end

        @(negedge clk_i);
        chk("final_pready", {31'b0, apb_bus.pready}, 32'd0);
        chk("final_prdata_hold", apb_bus.prdata, last_prdata);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
